// File: rtl/mult_pkg.sv
// Shared multiplier definitions: controller state encoding and the radix-4 Booth digit format.
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mult_state_e;

  // Digit value = (zero ? 0 : (times2 ? 2 : 1)) * (negate ? -1 : +1)
  typedef struct packed {
    logic negate;
    logic times2;
    logic zero;
  } booth_digit_t;

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth recoder: maps the window {b[2i+1], b[2i], b[2i-1]} to a signed digit.
module booth_r4_encoder
  import mult_pkg::*;
(
  input  logic [2:0]   window,
  output booth_digit_t digit
);

  always_comb begin
    digit.zero   = (window == 3'b000) || (window == 3'b111);
    digit.times2 = (window == 3'b011) || (window == 3'b100);
    // 3'b111 is -0, so it is reported as a plain zero rather than a negated one
    digit.negate = window[2] && !(window[1] && window[0]);
  end

endmodule

// File: rtl/seq_booth_multiplier.sv
// Sequential radix-4 Booth multiplier: one Booth digit per RUN cycle, WIDTH/2+1 cycles per product,
// valid/ready handshakes on both the operand and the result side.
module seq_booth_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter bit REG_OUT = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               busy
);

  localparam int N     = WIDTH / 2 + 1;
  localparam int ACC_W = 2 * WIDTH + 4;
  localparam int MB_W  = WIDTH + 3;
  localparam int CNT_W = $clog2(N);

  generate
    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
      $error("seq_booth_multiplier: WIDTH must be even and >= 4");
    end
  endgenerate

  mult_state_e      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [ACC_W-1:0] acc_reg, acc_next;
  logic [ACC_W-1:0] mcand_reg, mcand_next;
  logic [MB_W-1:0]  mplier_reg, mplier_next;
  logic             last_iter;

  booth_digit_t     digit;
  logic [ACC_W-1:0] mag_term;
  logic [ACC_W-1:0] add_term;

  booth_r4_encoder u_encoder (
    .window (mplier_reg[2:0]),
    .digit  (digit)
  );

  // Multiplicand is pre-shifted by 2*i, so the digit only ever selects 0, 1x or 2x of it
  always_comb begin
    mag_term = '0;
    if (!digit.zero) begin
      mag_term = digit.times2 ? {mcand_reg[ACC_W-2:0], 1'b0} : mcand_reg;
    end
    add_term = digit.negate ? (~mag_term + ACC_W'(1)) : mag_term;
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    acc_next    = acc_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    last_iter   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          // Extension to WIDTH+2 bits lets one Booth pass serve both signed and unsigned operands
          mcand_next  = signed_mode ? {{(WIDTH + 4){a[WIDTH-1]}}, a} : {{(WIDTH + 4){1'b0}}, a};
          mplier_next = {(signed_mode ? {2{b[WIDTH-1]}} : 2'b00), b, 1'b0};
          acc_next    = '0;
          cnt_next    = '0;
          state_next  = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_next    = acc_reg + add_term;
        mcand_next  = {mcand_reg[ACC_W-3:0], 2'b00};
        mplier_next = {2'b00, mplier_reg[MB_W-1:2]};
        cnt_next    = cnt_reg + CNT_W'(1);
        if (cnt_reg == CNT_W'(N - 1)) begin
          cnt_next   = '0;
          last_iter  = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
    end
  end

  generate
    if (REG_OUT) begin : g_reg_out
      logic [2*WIDTH-1:0] result_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          result_reg <= '0;
        end else if (last_iter) begin
          result_reg <= acc_next[2*WIDTH-1:0];
        end
      end
      assign result = result_reg;
    end else begin : g_comb_out
      assign result = acc_reg[2*WIDTH-1:0];
    end
  endgenerate

  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_DONE);
  assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Self-checking bench for seq_booth_multiplier (WIDTH = 32, registered result).
module tb_seq_booth_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        signed_mode;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[12];

  seq_booth_multiplier #(.WIDTH(32), .REG_OUT(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic [63:0] xe, ye;
    xe = s ? {{32{x[31]}}, x} : {32'b0, x};
    ye = s ? {{32{y[31]}}, y} : {32'b0, y};
    return xe * ye;
  endfunction

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Scoreboard: every completed result handshake pops one expected product
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL stale_out_valid: got result %h expected no output", result);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if (result !== e) begin
          errors++;
          $display("FAIL result: got %h expected %h", result, e);
        end else begin
          $display("result %h ok", result);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accept edge
  task automatic do_op(input logic [31:0] op_a, input logic [31:0] op_b, input logic op_s,
                       input logic [63:0] exp, input bit track);
    int waited;
    waited = 0;
    while (!in_ready && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1");
      return;
    end
    a = op_a;
    b = op_b;
    signed_mode = op_s;
    in_valid = 1'b1;
    @(posedge clk);
    if (track) exp_q.push_back(exp);
    $display("op a=%h b=%h signed=%0d", op_a, op_b, op_s);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int cyc;
    logic [63:0] held;
    logic [31:0] specials[6];

    vecs[0]  = '{32'hFFFFFFF9, 32'h00000003, 1'b1, 64'hFFFFFFFFFFFFFFEB};
    vecs[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001};
    vecs[2]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001};
    vecs[3]  = '{32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000};
    vecs[4]  = '{32'h80000000, 32'h00000001, 1'b1, 64'hFFFFFFFF80000000};
    vecs[5]  = '{32'h80000000, 32'h80000000, 1'b0, 64'h4000000000000000};
    vecs[6]  = '{32'h00000006, 32'h00000007, 1'b0, 64'h000000000000002A};
    vecs[7]  = '{32'h12345678, 32'h00000000, 1'b1, 64'h0000000000000000};
    vecs[8]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 64'h00000000FFFFFFFF};
    vecs[9]  = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 64'hFFFFFFFFFFFFFFFF};
    vecs[10] = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 64'hC000000080000000};
    vecs[11] = '{32'h00000000, 32'hFFFFFFFF, 1'b0, 64'h0000000000000000};
    specials = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFF9};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; signed_mode = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_result", result, 64'd0);

    // Latency, backpressure and held result on the -7 x 3 case
    out_ready = 1'b0;
    do_op(32'hFFFFFFF9, 32'h00000003, 1'b1, 64'hFFFFFFFFFFFFFFEB, 1'b1);
    check("run_busy", 64'(busy), 64'd1);
    check("run_in_ready", 64'(in_ready), 64'd0);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", 64'(cyc), 64'd17);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      a = 32'hDEAD0000 + 32'(i);
      b = 32'h5;
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_result", result, 64'hFFFFFFFFFFFFFFEB);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_done_in_ready", 64'(in_ready), 64'd1);
    check("post_done_out_valid", 64'(out_valid), 64'd0);
    check("held_result", result, 64'hFFFFFFFFFFFFFFEB);
    repeat (3) @(posedge clk);
    #1 check("idle_busy", 64'(busy), 64'd0);

    // Table of directed operand pairs
    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp, 1'b1);
    end
    drain();

    // Reset at iteration 8 discards the operation in flight
    do_op(32'd123, 32'd456, 1'b0, 64'd0, 1'b0);
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_result", result, 64'd0);
    do_op(32'd6, 32'd7, 1'b0, 64'd42, 1'b1);
    drain();
    repeat (25) @(posedge clk);
    #1 check("no_stale_busy", 64'(busy), 64'd0);

    // One-cycle in_ready gap between back-to-back operations
    do_op(32'd9, 32'hFFFFFFFE, 1'b1, 64'hFFFFFFFFFFFFFFEE, 1'b1);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("b2b_done_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    check("b2b_gap_in_ready", 64'(in_ready), 64'd1);
    check("b2b_gap_out_valid", 64'(out_valid), 64'd0);
    do_op(32'd3, 32'd5, 1'b0, 64'd15, 1'b1);
    drain();

    // Randomised operations against the reference model
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] ra, rb;
      logic rs;
      ra = ($urandom_range(0, 7) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 7) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      rs = 1'($urandom_range(0, 1));
      do_op(ra, rb, rs, ref_mul(ra, rb, rs), 1'b1);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
